// File: rtl/cpu6502_pkg.sv
// Shared 6502 core definitions: interrupt source encoding and the opcodes
// that the pre-decode stage treats specially.
package cpu6502_pkg;

  typedef enum logic [1:0] {
    INT_NONE = 2'b00,
    INT_IRQ  = 2'b01,
    INT_NMI  = 2'b10,
    INT_RST  = 2'b11
  } int_type_t;

  localparam logic [7:0] OPC_BRK = 8'h00;
  localparam logic [7:0] OPC_PHP = 8'h08;
  localparam logic [7:0] OPC_PLP = 8'h28;
  localparam logic [7:0] OPC_PHA = 8'h48;
  localparam logic [7:0] OPC_PLA = 8'h68;

endpackage

// File: rtl/predecode_unit_if.sv
// Bus between the pre-decode stage and its neighbours: memory data,
// controller handshake, interrupt pins and the pre-decode results.
interface predecode_unit_if;
  logic       rdy;
  logic [7:0] DB;
  logic       sync;
  logic       nmi_n;
  logic       irq_n;
  logic       I_flag;
  logic       int_ack;
  logic [7:0] PD;
  logic       pd_implied;
  logic       pd_two_cycle;
  logic       int_active;
  logic [1:0] int_type;

  modport master (
    output rdy, DB, sync, nmi_n, irq_n, I_flag, int_ack,
    input  PD, pd_implied, pd_two_cycle, int_active, int_type
  );

  modport slave (
    input  rdy, DB, sync, nmi_n, irq_n, I_flag, int_ack,
    output PD, pd_implied, pd_two_cycle, int_active, int_type
  );
endinterface

// File: rtl/int_arbiter.sv
// Interrupt source tracking: NMI falling-edge capture, RESET/NMI pending
// flags and fixed-priority selection of the source to inject.
module int_arbiter
  import cpu6502_pkg::*;
(
  input  logic      i_clk_ph1,
  input  logic      i_rst,
  input  logic      i_rdy,
  input  logic      i_nmi_n,
  input  logic      i_irq_n,
  input  logic      i_i_flag,
  input  logic      i_int_ack,
  input  int_type_t i_int_type,
  output int_type_t o_int_sel,
  output logic      o_pending
);

  logic r_nmi_prev;
  logic r_nmi_pending;
  logic r_rst_pending;
  logic w_nmi_edge;
  logic w_irq_req;
  logic w_ack;

  assign w_nmi_edge = r_nmi_prev & ~i_nmi_n;
  assign w_irq_req  = ~i_irq_n & ~i_i_flag;
  assign w_ack      = i_rdy & i_int_ack;

  // Edge capture runs even while stalled so a short NMI pulse is never lost.
  always_ff @(posedge i_clk_ph1) begin
    if (!i_rst) begin
      r_nmi_prev    <= 1'b1;
      r_nmi_pending <= 1'b0;
      r_rst_pending <= 1'b1;
    end else begin
      r_nmi_prev <= i_nmi_n;
      if (w_nmi_edge)
        r_nmi_pending <= 1'b1;
      else if (w_ack && i_int_type == INT_NMI)
        r_nmi_pending <= 1'b0;
      if (w_ack && i_int_type == INT_RST)
        r_rst_pending <= 1'b0;
    end
  end

  always_comb begin
    o_int_sel = INT_NONE;
    if (r_rst_pending)
      o_int_sel = INT_RST;
    else if (r_nmi_pending)
      o_int_sel = INT_NMI;
    else if (w_irq_req)
      o_int_sel = INT_IRQ;
  end

  assign o_pending = (o_int_sel != INT_NONE);

endmodule

// File: rtl/predecode_unit.sv
// Opcode pre-decode stage: latches the bus byte into PD, substitutes BRK at
// opcode fetch when an interrupt is pending, and flags implied opcodes.
module predecode_unit
  import cpu6502_pkg::*;
#(
  parameter logic [7:0] BRK_OPCODE = OPC_BRK
) (
  input  logic             clk_ph1,
  input  logic             rst,
  predecode_unit_if.slave  bus
);

  logic [7:0] r_pd;
  logic       r_int_active;
  int_type_t  r_int_type;
  int_type_t  w_int_sel;
  logic       w_pending;
  logic       w_implied;
  logic       w_stack_op;

  int_arbiter u_int_arbiter (
    .i_clk_ph1  (clk_ph1),
    .i_rst      (rst),
    .i_rdy      (bus.rdy),
    .i_nmi_n    (bus.nmi_n),
    .i_irq_n    (bus.irq_n),
    .i_i_flag   (bus.I_flag),
    .i_int_ack  (bus.int_ack),
    .i_int_type (r_int_type),
    .o_int_sel  (w_int_sel),
    .o_pending  (w_pending)
  );

  always_ff @(posedge clk_ph1) begin
    if (!rst) begin
      r_pd         <= 8'h00;
      r_int_active <= 1'b0;
      r_int_type   <= INT_NONE;
    end else if (bus.rdy) begin
      if (bus.sync && w_pending) begin
        r_pd         <= BRK_OPCODE;
        r_int_active <= 1'b1;
        r_int_type   <= w_int_sel;
      end else begin
        r_pd <= bus.DB;
        if (bus.sync) begin
          r_int_active <= 1'b0;
          r_int_type   <= INT_NONE;
        end
      end
    end
  end

  // Single-byte opcodes: column 8, the accumulator/transfer column A in the
  // low half of each row pair, plus TXS and TSX.
  assign w_implied  = (r_pd[3:0] == 4'h8)
                    | ((r_pd[3:0] == 4'hA) & ~r_pd[4])
                    | (r_pd == 8'h9A)
                    | (r_pd == 8'hBA);
  assign w_stack_op = (r_pd == OPC_PHP) | (r_pd == OPC_PLP)
                    | (r_pd == OPC_PHA) | (r_pd == OPC_PLA);

  assign bus.PD           = r_pd;
  assign bus.pd_implied   = w_implied;
  assign bus.pd_two_cycle = w_implied & ~w_stack_op;
  assign bus.int_active   = r_int_active;
  assign bus.int_type     = r_int_type;

endmodule

// File: tb/tb_predecode_unit.sv
// Bench for predecode_unit: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural model.
module tb_predecode_unit;

  logic clk_ph1 = 1'b0;
  logic rst     = 1'b0;
  always #5 clk_ph1 = ~clk_ph1;

  predecode_unit_if bus ();

  predecode_unit dut (
    .clk_ph1 (clk_ph1),
    .rst     (rst),
    .bus     (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Behavioural model state
  logic       m_valid = 1'b0;
  logic [7:0] m_pd;
  logic       m_act;
  logic [1:0] m_type;
  logic       m_nmi_pend, m_nmi_prev, m_rst_pend;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
  endtask

  function automatic logic exp_implied(input logic [7:0] op);
    logic [7:0] singles [10] = '{8'h0A, 8'h2A, 8'h4A, 8'h6A, 8'h8A,
                                 8'hAA, 8'hCA, 8'hEA, 8'h9A, 8'hBA};
    if (op[3:0] == 4'h8) return 1'b1;
    foreach (singles[k]) if (singles[k] == op) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic exp_two_cycle(input logic [7:0] op);
    return exp_implied(op) && !(op == 8'h08 || op == 8'h28 || op == 8'h48 || op == 8'h68);
  endfunction

  // Model: advance one ph1 edge from the inputs currently on the bus.
  always @(posedge clk_ph1) begin
    if (!rst) begin
      m_pd = 8'h00; m_act = 1'b0; m_type = 2'd0;
      m_nmi_pend = 1'b0; m_nmi_prev = 1'b1; m_rst_pend = 1'b1;
      m_valid = 1'b1;
    end else if (m_valid) begin
      logic       edge_seen;
      logic [1:0] src;
      edge_seen = m_nmi_prev && !bus.nmi_n;
      m_nmi_prev = bus.nmi_n;
      if (m_rst_pend)                     src = 2'd3;
      else if (m_nmi_pend)                src = 2'd2;
      else if (!bus.irq_n && !bus.I_flag) src = 2'd1;
      else                                src = 2'd0;
      if (bus.rdy && bus.int_ack) begin
        if (m_type == 2'd3) m_rst_pend = 1'b0;
        if (m_type == 2'd2) m_nmi_pend = 1'b0;
      end
      if (edge_seen) m_nmi_pend = 1'b1;
      if (bus.rdy) begin
        if (bus.sync && src != 2'd0) begin
          m_pd = 8'h00; m_act = 1'b1; m_type = src;
        end else begin
          m_pd = bus.DB;
          if (bus.sync) begin m_act = 1'b0; m_type = 2'd0; end
        end
      end
    end
  end

  always @(negedge clk_ph1) begin
    if (m_valid) begin
      chk("model_pd",        bus.PD,                   m_pd);
      chk("model_int_active", {7'd0, bus.int_active},  {7'd0, m_act});
      chk("model_int_type",  {6'd0, bus.int_type},     {6'd0, m_type});
      chk("model_implied",   {7'd0, bus.pd_implied},   {7'd0, exp_implied(m_pd)});
      chk("model_two_cycle", {7'd0, bus.pd_two_cycle}, {7'd0, exp_two_cycle(m_pd)});
    end
  end

  task automatic tick(input logic r, input logic sy, input logic [7:0] db,
                      input logic nmi, input logic irq, input logic ifl, input logic ack);
    bus.rdy = r; bus.sync = sy; bus.DB = db;
    bus.nmi_n = nmi; bus.irq_n = irq; bus.I_flag = ifl; bus.int_ack = ack;
    @(posedge clk_ph1);
    #2;
  endtask

  task automatic chk_out(input string name, input logic [7:0] pd, input logic act, input logic [1:0] ty);
    chk({name, "_pd"},   bus.PD,               pd);
    chk({name, "_act"},  {7'd0, bus.int_active}, {7'd0, act});
    chk({name, "_type"}, {6'd0, bus.int_type},   {6'd0, ty});
  endtask

  initial begin
    logic [7:0] opv [5]  = '{8'h0A, 8'h9A, 8'h48, 8'hEA, 8'h4C};
    logic       impv [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic       twov [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

    rst = 1'b0;
    tick(1, 0, 8'h00, 1, 1, 1, 0);
    tick(1, 0, 8'h00, 1, 1, 1, 0);
    chk_out("reset", 8'h00, 0, 2'd0);
    rst = 1'b1;

    // 1: RESET injection then normal fetch
    tick(1, 1, 8'hA9, 1, 1, 1, 0);  chk_out("rst_inject", 8'h00, 1, 2'd3);
    tick(1, 0, 8'h12, 1, 1, 1, 1);  chk_out("rst_ack", 8'h12, 1, 2'd3);
    tick(1, 1, 8'hA9, 1, 1, 1, 0);  chk_out("rst_done", 8'hA9, 0, 2'd0);

    // 2: NMI edge during stall
    tick(0, 1, 8'h77, 0, 1, 1, 0);  chk_out("nmi_stall", 8'hA9, 0, 2'd0);
    tick(1, 1, 8'hA9, 0, 1, 1, 0);  chk_out("nmi_inject", 8'h00, 1, 2'd2);
    tick(1, 0, 8'h55, 0, 1, 1, 1);
    tick(1, 1, 8'h20, 0, 1, 1, 0);  chk_out("nmi_level_no_reinject", 8'h20, 0, 2'd0);
    tick(1, 0, 8'h00, 1, 1, 1, 0);

    // 3: IRQ masked then unmasked
    tick(1, 1, 8'h77, 1, 0, 1, 0);  chk_out("irq_masked", 8'h77, 0, 2'd0);
    tick(1, 1, 8'h77, 1, 0, 0, 0);  chk_out("irq_inject", 8'h00, 1, 2'd1);
    tick(1, 0, 8'h01, 1, 1, 0, 1);
    tick(1, 1, 8'h33, 1, 1, 0, 0);  chk_out("irq_gone", 8'h33, 0, 2'd0);

    // 4: NMI beats IRQ, IRQ follows
    tick(1, 0, 8'h11, 0, 0, 0, 0);
    tick(1, 1, 8'h11, 0, 0, 0, 0);  chk_out("nmi_over_irq", 8'h00, 1, 2'd2);
    tick(1, 0, 8'h02, 0, 0, 0, 1);
    tick(1, 1, 8'h11, 0, 0, 0, 0);  chk_out("irq_after_nmi", 8'h00, 1, 2'd1);
    tick(1, 0, 8'h03, 1, 1, 0, 1);

    // 5: new NMI edge coincident with NMI ack
    tick(1, 0, 8'h04, 0, 1, 1, 0);
    tick(1, 1, 8'h44, 0, 1, 1, 0);  chk_out("nmi5_inject", 8'h00, 1, 2'd2);
    tick(1, 0, 8'h05, 1, 1, 1, 0);
    tick(1, 0, 8'h06, 0, 1, 1, 1);
    tick(1, 1, 8'h44, 0, 1, 1, 0);  chk_out("nmi5_reinject", 8'h00, 1, 2'd2);
    tick(1, 0, 8'h07, 1, 1, 1, 1);
    tick(1, 1, 8'h44, 1, 1, 1, 0);  chk_out("nmi5_done", 8'h44, 0, 2'd0);

    // 6: pre-decode flags
    for (int i = 0; i < 5; i++) begin
      tick(1, 0, opv[i], 1, 1, 1, 0);
      chk("flag_implied",   {7'd0, bus.pd_implied},   {7'd0, impv[i]});
      chk("flag_two_cycle", {7'd0, bus.pd_two_cycle}, {7'd0, twov[i]});
    end

    // Reset mid-instruction
    rst = 1'b0;
    tick(1, 0, 8'hEE, 1, 1, 1, 0);  chk_out("midrst", 8'h00, 0, 2'd0);
    rst = 1'b1;
    tick(1, 1, 8'hEE, 1, 1, 1, 0);  chk_out("midrst_inject", 8'h00, 1, 2'd3);

    // Randomized traffic; the model comparator checks every cycle.
    for (int i = 0; i < 3000; i++) begin
      logic nmi_v;
      rst = ($urandom_range(0, 199) != 0);
      nmi_v = ($urandom_range(0, 7) != 0);
      tick($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, 8'($urandom),
           nmi_v, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
           $urandom_range(0, 7) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
